// File: rtl/round_sequencer.sv
// Reaction-light round controller: picks a target light from the LFSR, times a
// response window that shrinks with each hit, grades presses, counts hits/misses/rounds.
module round_sequencer #(
   parameter int unsigned ROUNDS     = 10,
   parameter int unsigned MAX_MISS   = 3,
   parameter int unsigned BASE_TICKS = 50_000_000,
   parameter int unsigned STEP_TICKS = 2_500_000,
   parameter int unsigned MIN_TICKS  = 10_000_000,
   parameter int unsigned GAP_TICKS  = 12_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [3:0] rand_i,
   input  logic [3:0] btn_i,
   output logic [3:0] lights_o,
   output logic [6:0] hits_o,
   output logic [6:0] misses_o,
   output logic [6:0] round_o,
   output logic       hit_pulse_o,
   output logic       miss_pulse_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARM  = 3'd1;
   localparam logic [2:0] S_SHOW = 3'd2;
   localparam logic [2:0] S_HIT  = 3'd3;
   localparam logic [2:0] S_MISS = 3'd4;
   localparam logic [2:0] S_GAP  = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;

   localparam logic [31:0] BASE_C     = 32'(BASE_TICKS);
   localparam logic [31:0] STEP_C     = 32'(STEP_TICKS);
   localparam logic [31:0] MIN_C      = 32'(MIN_TICKS);
   localparam logic [31:0] GAP_C      = 32'(GAP_TICKS);
   localparam logic [6:0]  ROUNDS_C   = 7'(ROUNDS);
   localparam logic [6:0]  MAX_MISS_C = 7'(MAX_MISS);
   localparam logic [6:0]  HIT_SAT_C  = 7'd99;

   logic [2:0]  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] window_q, window_d;
   logic [1:0]  target_q, target_d;
   logic [6:0]  hits_q, hits_d;
   logic [6:0]  misses_q, misses_d;
   logic [6:0]  round_q, round_d;
   logic [3:0]  lights_q, lights_d;
   logic        hit_pulse_q, hit_pulse_d;
   logic        miss_pulse_q, miss_pulse_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        start_q;
   logic [3:0]  btn_q;

   logic        start_ev;
   logic [3:0]  press;
   logic [3:0]  target_oh;
   logic        unused_rand;

   assign start_ev    = start_i & ~start_q;
   assign press       = btn_i & ~btn_q;
   assign target_oh   = 4'b0001 << target_q;
   assign unused_rand = ^rand_i[3:2];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      window_d     = window_q;
      target_d     = target_q;
      hits_d       = hits_q;
      misses_d     = misses_q;
      round_d      = round_q;
      lights_d     = lights_q;
      hit_pulse_d  = 1'b0;
      miss_pulse_d = 1'b0;
      busy_d       = busy_q;
      done_d       = done_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_ev) begin
               hits_d   = '0;
               misses_d = '0;
               round_d  = '0;
               window_d = BASE_C;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               lights_d = '0;
               state_d  = S_ARM;
            end
         end
         S_ARM: begin
            // never repeat the previous target back to back
            target_d = (rand_i[1:0] == target_q) ? rand_i[1:0] + 2'd1 : rand_i[1:0];
            lights_d = 4'b0001 << target_d;
            cnt_d    = window_q;
            state_d  = S_SHOW;
         end
         S_SHOW: begin
            cnt_d = cnt_q - 32'd1;
            if (press == target_oh) begin
               state_d = S_HIT;
            end else if (press != 4'b0000) begin
               state_d = S_MISS;
            end else if (cnt_q == 32'd1) begin
               state_d = S_MISS;
            end
         end
         S_HIT: begin
            hits_d      = (hits_q >= HIT_SAT_C) ? hits_q : hits_q + 7'd1;
            round_d     = round_q + 7'd1;
            window_d    = (window_q >= STEP_C && (window_q - STEP_C) > MIN_C) ?
                          window_q - STEP_C : MIN_C;
            hit_pulse_d = 1'b1;
            lights_d    = '0;
            cnt_d       = GAP_C;
            state_d     = S_GAP;
         end
         S_MISS: begin
            misses_d     = misses_q + 7'd1;
            round_d      = round_q + 7'd1;
            miss_pulse_d = 1'b1;
            lights_d     = '0;
            cnt_d        = GAP_C;
            state_d      = S_GAP;
         end
         S_GAP: begin
            cnt_d = cnt_q - 32'd1;
            if (cnt_q == 32'd1) begin
               if (round_q == ROUNDS_C || misses_q == MAX_MISS_C) begin
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  lights_d = 4'b1111;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_ARM;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         window_q     <= BASE_C;
         target_q     <= '0;
         hits_q       <= '0;
         misses_q     <= '0;
         round_q      <= '0;
         lights_q     <= '0;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         start_q      <= 1'b0;
         btn_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         window_q     <= window_d;
         target_q     <= target_d;
         hits_q       <= hits_d;
         misses_q     <= misses_d;
         round_q      <= round_d;
         lights_q     <= lights_d;
         hit_pulse_q  <= hit_pulse_d;
         miss_pulse_q <= miss_pulse_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         start_q      <= start_i;
         btn_q        <= btn_i;
      end
   end

   assign lights_o     = lights_q;
   assign hits_o       = hits_q;
   assign misses_o     = misses_q;
   assign round_o      = round_q;
   assign hit_pulse_o  = hit_pulse_q;
   assign miss_pulse_o = miss_pulse_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: a game-level model predicts every target
// light and every graded pulse; a monitor compares them as the DUT presents them.
module tb_round_sequencer;
   localparam int ROUNDS   = 3;
   localparam int MAX_MISS = 2;
   localparam int BASE     = 8;
   localparam int STEP     = 2;
   localparam int MIN_T    = 4;
   localparam int GAP      = 2;

   localparam int A_HIT   = 0;
   localparam int A_WRONG = 1;
   localparam int A_MULTI = 2;
   localparam int A_NONE  = 3;
   localparam int A_HELD  = 4;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       start_i = 1'b0;
   logic [3:0] rand_i  = 4'd0;
   logic [3:0] btn_i   = 4'd0;
   logic [3:0] lights_o;
   logic [6:0] hits_o, misses_o, round_o;
   logic       hit_pulse_o, miss_pulse_o, busy_o, done_o;

   round_sequencer #(
      .ROUNDS(ROUNDS), .MAX_MISS(MAX_MISS), .BASE_TICKS(BASE),
      .STEP_TICKS(STEP), .MIN_TICKS(MIN_T), .GAP_TICKS(GAP)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .rand_i(rand_i), .btn_i(btn_i),
      .lights_o(lights_o), .hits_o(hits_o), .misses_o(misses_o), .round_o(round_o),
      .hit_pulse_o(hit_pulse_o), .miss_pulse_o(miss_pulse_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { bit hit; int hits; int misses; int rnd; int cyc; } pulse_t;
   typedef struct { int tgt; int cyc; } tgt_t;
   pulse_t pulse_q[$];
   tgt_t   tgt_q[$];

   int vectors = 0;
   int miscompares = 0;

   int m_prev = 0;
   int m_hits, m_misses, m_round, m_window;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   function automatic int next_target(input int r);
      int t;
      t = (r == m_prev) ? (r + 1) % 4 : r;
      m_prev = t;
      return t;
   endfunction

   function automatic logic [3:0] press_vec(input int act, input int t);
      int o;
      logic [3:0] v;
      o = (t + int'($urandom_range(1, 3))) % 4;
      v = 4'b0001 << t;
      if (act == A_WRONG) v = 4'b0001 << o;
      else if (act == A_MULTI) v = v | (4'b0001 << o);
      return v;
   endfunction

   task automatic pick_action(input int mode, input int w, output int act, output int j);
      j = int'($urandom_range(1, w));
      case (mode)
         1: begin act = A_HIT; j = 3; end
         2: act = A_NONE;
         3: act = (m_round == 0) ? A_WRONG : A_MULTI;
         4: begin act = A_HIT; j = w; end
         5: act = A_HIT;
         6: act = (m_round < 2) ? A_HIT : A_NONE;
         default: act = int'($urandom_range(0, 4));
      endcase
   endtask

   // Sets up the next round's LFSR value and action, and records the expected target.
   task automatic setup_round(input int mode, input int lcyc, output int t,
                              output int act, output int j);
      int r;
      r = (mode == 5) ? 2 : int'($urandom_range(0, 3));
      rand_i = {2'($urandom), 2'(r)};
      t = next_target(r);
      pick_action(mode, m_window, act, j);
      if (act == A_HELD) btn_i = 4'b0001 << t;
      tgt_q.push_back('{t, lcyc});
   endtask

   task automatic play_game(input int mode);
      int c, L, P, w, j, act, t;
      bit over, pressed;
      logic [3:0] vec;
      c = cyc;
      m_hits = 0; m_misses = 0; m_round = 0; m_window = BASE;
      L = c + 2;
      setup_round(mode, L, t, act, j);
      start_i = 1'b1;
      wait_until(c + 1);
      start_i = 1'b0;
      chk("busy_after_start", busy_o, 1);
      chk("done_after_start", done_o, 0);
      chk("hits_cleared", hits_o, 0);
      chk("misses_cleared", misses_o, 0);
      chk("round_cleared", round_o, 0);
      over = 1'b0;
      while (!over) begin
         w = m_window;
         vec = press_vec(act, t);
         pressed = (act == A_HIT || act == A_WRONG || act == A_MULTI);
         P = pressed ? L + j + 1 : L + w + 1;
         if (act == A_HIT) begin
            m_hits = (m_hits >= 99) ? 99 : m_hits + 1;
            m_window = (m_window - STEP < MIN_T) ? MIN_T : m_window - STEP;
         end else begin
            m_misses++;
         end
         m_round++;
         pulse_q.push_back('{act == A_HIT, m_hits, m_misses, m_round, P});
         over = (m_round == ROUNDS) || (m_misses == MAX_MISS);

         wait_until(L);
         start_i = 1'($urandom_range(0, 1));   // a start while busy must do nothing
         if (pressed && j == 1) btn_i = vec;
         wait_until(L + 1);
         start_i = 1'b0;
         if (pressed) begin
            if (j > 1) begin
               wait_until(L + j - 1);
               btn_i = vec;
               wait_until(L + j);
            end
            btn_i = 4'd0;
         end
         wait_until(P);
         btn_i = 4'd0;
         if (!over) begin
            L = P + GAP + 1;
            setup_round(mode, L, t, act, j);
         end
      end
      wait_until(P + GAP);
      chk("done_flag", done_o, 1);
      chk("busy_in_done", busy_o, 0);
      chk("lights_in_done", lights_o, 4'b1111);
      chk("final_hits", hits_o, m_hits);
      chk("final_misses", misses_o, m_misses);
      chk("final_round", round_o, m_round);
      wait_until(cyc + int'($urandom_range(0, 3)));
      chk("round_holds_in_done", round_o, m_round);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_lights"}, lights_o, 0);
      chk({tag, "_hits"}, hits_o, 0);
      chk({tag, "_misses"}, misses_o, 0);
      chk({tag, "_round"}, round_o, 0);
      chk({tag, "_hit_pulse"}, hit_pulse_o, 0);
      chk({tag, "_miss_pulse"}, miss_pulse_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
   endtask

   task automatic reset_mid_show();
      int c, t, act, j;
      c = cyc;
      m_window = BASE;
      setup_round(7, c + 2, t, act, j);
      btn_i = 4'd0;
      start_i = 1'b1;
      wait_until(c + 1);
      start_i = 1'b0;
      wait_until(c + 4);
      chk("lights_before_rst", lights_o, 32'(4'b0001 << t));
      #2 rst = 1'b1;
      #1 check_all_zero("rst_async");
      m_prev = 0;
      pulse_q.delete();
      tgt_q.delete();
      wait_until(cyc + 2);
      rst = 1'b0;
      wait_until(cyc + 3);
      check_all_zero("idle_after_rst");
   endtask

   bit prev_oh = 1'b0;
   always @(negedge clk) begin
      pulse_t e;
      tgt_t   g;
      bit     oh;
      if (rst) begin
         prev_oh = 1'b0;
      end else begin
         if (hit_pulse_o || miss_pulse_o) begin
            if (pulse_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_pulse: got hit=%0b miss=%0b expected none (cycle %0d)",
                        hit_pulse_o, miss_pulse_o, cyc);
            end else begin
               e = pulse_q.pop_front();
               chk("pulse_hit", hit_pulse_o, e.hit);
               chk("pulse_miss", miss_pulse_o, !e.hit);
               chk("pulse_cycle", cyc, e.cyc);
               chk("pulse_hits", hits_o, e.hits);
               chk("pulse_misses", misses_o, e.misses);
               chk("pulse_round", round_o, e.rnd);
               chk("lights_at_pulse", lights_o, 0);
            end
         end
         oh = $onehot(lights_o);
         if (oh && !prev_oh) begin
            if (tgt_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_light: got %b expected none (cycle %0d)", lights_o, cyc);
            end else begin
               g = tgt_q.pop_front();
               chk("target_light", lights_o, 32'(1) << g.tgt);
               chk("light_cycle", cyc, g.cyc);
            end
         end
         prev_oh = oh;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish by cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      wait_until(cyc + 2);
      check_all_zero("idle");
      play_game(5);
      play_game(1);
      play_game(2);
      play_game(3);
      play_game(4);
      play_game(6);
      reset_mid_show();
      play_game(5);
      for (int g = 0; g < 40; g++) play_game(0);
      wait_until(cyc + 5);
      chk("pulse_queue_drained", pulse_q.size(), 0);
      chk("target_queue_drained", tgt_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/round_sequencer.md
# round_sequencer

Game-round controller for the reaction-light game. It takes the free-running LFSR value and picks a target light each round. It opens a response window that shrinks as the player scores, grades button presses as hit or miss, and keeps the hit, miss and round counts that drive the seven-segment display. It stops the game after a fixed round count or a miss limit.

## Interface
- ROUNDS, 10: rounds per game (1..127)
- MAX_MISS, 3: misses that end the game early (1..127)
- BASE_TICKS, 50_000_000: initial response window in clk cycles (>= MIN_TICKS)
- STEP_TICKS, 2_500_000: window reduction per hit
- MIN_TICKS, 10_000_000: window floor (>= 1)
- GAP_TICKS, 12_500_000: dark interval between rounds (>= 1)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level; its rising edge starts or restarts a game
- rand  in  4  free-running LFSR value; only rand[1:0] is used
- btn  in  4  buttons, already synchronized and debounced to clk, active-high
- lights  out  4  one-hot target light
- hits  out  7  hit count, saturates at 99
- misses  out  7  miss count
- round  out  7  completed rounds
- hit_pulse  out  1  one-cycle pulse per graded hit
- miss_pulse  out  1  one-cycle pulse per graded miss
- busy  out  1  high while a game is in progress
- done  out  1  high in DONE

## Operation
- Edge detection: start_q and btn_q are registered copies of start and btn.
  - Start event = start & ~start_q.
  - Press vector = btn & ~btn_q.
- States: IDLE, ARM, SHOW, HIT, MISS, GAP, DONE.
- IDLE: lights=0. A start event clears hits, misses and round, loads window=BASE_TICKS, sets busy, and goes to ARM.
- ARM (1 cycle):
  - The target is rand[1:0]. If that equals the previous target, the target is rand[1:0]+1 mod 4. The previous target resets to 0.
  - The countdown cnt is loaded with window. Next state is SHOW.
- SHOW:
  - lights = one-hot(target).
  - cnt decrements by 1 each cycle.
  - A press vector equal to exactly one-hot(target) goes to HIT.
  - Any other nonzero press vector (wrong button, or several buttons in the same cycle) goes to MISS.
  - cnt==1 with no press goes to MISS (timeout).
  - A correct press in the same cycle as expiry counts as HIT.
- HIT (1 cycle):
  - hits+1, saturating at 99.
  - round+1.
  - window = max(window-STEP_TICKS, MIN_TICKS), computed in 32 bits without underflow.
  - hit_pulse=1. cnt is loaded with GAP_TICKS. Next state is GAP.
- MISS (1 cycle): misses+1, round+1, miss_pulse=1, window unchanged, cnt loaded with GAP_TICKS. Next state is GAP.
- GAP:
  - lights=0. cnt decrements each cycle.
  - When cnt==1, go to DONE if round==ROUNDS or misses==MAX_MISS; otherwise go to ARM.
  - Presses during GAP are ignored.
- DONE:
  - busy=0, done=1, lights=4'b1111. Counters hold their values.
  - A start event clears the counters and reloads the window exactly as in IDLE, then goes to ARM.
- A start event while busy is ignored.

## Timing
- Reset values: lights=0, hits=0, misses=0, round=0, hit_pulse=0, miss_pulse=0, busy=0, done=0. State is IDLE, window=BASE_TICKS, cnt=0.
- Reset mid-game forces these values immediately, without waiting for a clock edge.
- All outputs are registered.
- From a start event sampled at edge N: busy=1 after edge N, state is ARM. lights become one-hot after edge N+1.
- SHOW lasts at most window cycles. A timeout asserts miss_pulse window+1 cycles after lights assert.
- Press latency: a rising btn edge at edge N (seen through btn_q) asserts the hit or miss pulse after edge N+1.
- lights clear in the same cycle the pulse asserts.
- GAP lasts exactly GAP_TICKS cycles.
- hits, misses and round update on the same edge that asserts the pulse.
- A button held from before SHOW starts produces no press; only a new rising edge counts.

## Test plan
Test parameters: ROUNDS=3, MAX_MISS=2, BASE_TICKS=8, STEP_TICKS=2, MIN_TICKS=4, GAP_TICKS=2.
- Reset mid-SHOW: assert rst -> all outputs 0 asynchronously; state IDLE after release.
- Start, then press the correct button 3 cycles after lights assert, three rounds in a row:
  - hits=1,2,3; round=3.
  - window=6,4, then clamps at 4.
  - done=1, lights=1111, busy=0.
- Start, press nothing:
  - miss_pulse 9 cycles after lights assert.
  - Second timeout -> misses=2 -> DONE with round=2.
- Press a wrong button, then press the target and another button in the same cycle -> two misses, DONE.
- Drive rand[1:0]=2 in consecutive ARMs -> targets 2 then 3 (lights 0100 then 1000).
- Correct press on the cycle cnt==1 -> HIT, not MISS.
- Start event while busy -> no effect.
- Start event in DONE -> counters 0, new game.
